// File: rtl/seq_shifter_pkg.sv
// Shared encodings for the sequential shifter: opcodes and controller states.
package seq_shifter_pkg;

  typedef enum logic [2:0] {
    OP_ASL = 3'b000,
    OP_LSL = 3'b001,
    OP_ROL = 3'b010,
    OP_PT0 = 3'b011,
    OP_ASR = 3'b100,
    OP_LSR = 3'b101,
    OP_ROR = 3'b110,
    OP_PT1 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Both x11 encodings bypass the shifter entirely.
  function automatic logic is_pass(input logic [2:0] op);
    return op[1] & op[0];
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One-bit shift/rotate step; sign_change flags a flip of the msb across the step.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] next_value,
  output logic             sign_change
);

  logic signed [WIDTH-1:0] value_s;

  always_comb begin
    value_s    = value;
    next_value = value;
    case (opcode)
      OP_ASL,
      OP_LSL:  next_value = {value[WIDTH-2:0], 1'b0};
      OP_ROL:  next_value = {value[WIDTH-2:0], value[WIDTH-1]};
      OP_ASR:  next_value = value_s >>> 1;
      OP_LSR:  next_value = {1'b0, value[WIDTH-1:1]};
      OP_ROR:  next_value = {value[0], value[WIDTH-1:1]};
      default: next_value = value;
    endcase
    sign_change = next_value[WIDTH-1] ^ value[WIDTH-1];
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit per cycle, valid/ready on both sides, no overlap
// between accepting a request and presenting its result.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    s,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             overflow,
  output logic             busy
);

  state_e           state;
  logic [WIDTH-1:0] work;
  logic [SW-1:0]    cnt;
  logic [2:0]       op_r;
  logic             ovf_acc;

  logic [WIDTH-1:0] step_next;
  logic             step_sc;
  logic             step_ovf;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value       (work),
    .opcode      (op_r),
    .next_value  (step_next),
    .sign_change (step_sc)
  );

  // Only an arithmetic left shift can report a sign change.
  assign step_ovf = (op_r == OP_ASL) && step_sc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      y         <= '0;
      overflow  <= 1'b0;
      cnt       <= '0;
      work      <= '0;
      op_r      <= '0;
      ovf_acc   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_r     <= opcode;
            work     <= a;
            cnt      <= s;
            ovf_acc  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (s == '0 || is_pass(opcode)) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              y         <= a;
              overflow  <= 1'b0;
            end else begin
              state <= ST_SHIFT;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end

        ST_SHIFT: begin
          work <= step_next;
          cnt  <= cnt - SW'(1);
          if (step_ovf) ovf_acc <= 1'b1;
          // Last step: publish the stepped value directly so the result is
          // available the same edge the counter expires.
          if (cnt == SW'(1)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            y         <= step_next;
            overflow  <= ovf_acc | step_ovf;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: directed requests push expectations,
// a negedge monitor pops and compares every presented result.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [2:0] s;
  logic [2:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       overflow;
  logic       busy;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(8), .SW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .s         (s),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .overflow  (overflow),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] y;
    logic       ovf;
    int         lat;
    int         acc;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   pcnt   = 0;
  bit   seen   = 1'b0;

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
  endtask

  // Monitor: latency on the first cycle of a result, value/flags every cycle it is held.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        if (!seen) begin
          chk({q[0].nm, "_latency"}, pcnt - q[0].acc + 1, q[0].lat);
          seen <= 1'b1;
        end
        chk({q[0].nm, "_y"}, {24'd0, y}, {24'd0, q[0].y});
        chk({q[0].nm, "_overflow"}, {31'd0, overflow}, {31'd0, q[0].ovf});
        chk({q[0].nm, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
        chk({q[0].nm, "_busy"}, {31'd0, busy}, 32'd1);
        if (out_ready) begin
          void'(q.pop_front());
          seen <= 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string nm, input logic [7:0] av, input logic [2:0] sv,
                      input logic [2:0] ov, input logic [7:0] ey, input logic eo,
                      input int lat, input bit push);
    exp_t it;
    int   guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
      return;
    end
    a        = av;
    s        = sv;
    opcode   = ov;
    in_valid = 1'b1;
    tick();
    if (push) begin
      it.y   = ey;
      it.ovf = eo;
      it.lat = lat;
      it.acc = pcnt;
      it.nm  = nm;
      q.push_back(it);
    end
    // Scramble the inputs; the DUT must have captured the request already.
    in_valid = 1'b0;
    a        = ~av;
    s        = sv + 3'd3;
    opcode   = ov ^ 3'b101;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 100) begin
      tick();
      guard++;
    end
    if (q.size() != 0 || out_valid) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    s         = '0;
    opcode    = '0;
    tick();
    tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_y",         {24'd0, y},         32'd0);
    chk("rst_overflow",  {31'd0, overflow},  32'd0);
    chk("rst_cnt",       {29'd0, dut.cnt},   32'd0);
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    //    name         a      s     op       y      ovf  lat
    send("asl_a6_4",  8'hA6, 3'd4, 3'b000, 8'h60, 1'b1, 5, 1'b1);
    send("lsl_a6_3",  8'hA6, 3'd3, 3'b001, 8'h30, 1'b0, 4, 1'b1);
    send("rol_a6_1",  8'hA6, 3'd1, 3'b010, 8'h4D, 1'b0, 2, 1'b1);
    send("asr_a6_3",  8'hA6, 3'd3, 3'b100, 8'hF4, 1'b0, 4, 1'b1);
    send("lsr_a6_5",  8'hA6, 3'd5, 3'b101, 8'h05, 1'b0, 6, 1'b1);
    send("ror_a6_2",  8'hA6, 3'd2, 3'b110, 8'hA9, 1'b0, 3, 1'b1);
    send("asl_40_1",  8'h40, 3'd1, 3'b000, 8'h80, 1'b1, 2, 1'b1);
    send("asl_c0_1",  8'hC0, 3'd1, 3'b000, 8'h80, 1'b0, 2, 1'b1);
    send("asl_c0_2",  8'hC0, 3'd2, 3'b000, 8'h00, 1'b1, 3, 1'b1);
    send("lsl_80_1",  8'h80, 3'd1, 3'b001, 8'h00, 1'b0, 2, 1'b1);
    send("asl_a6_0",  8'hA6, 3'd0, 3'b000, 8'hA6, 1'b0, 1, 1'b1);
    send("pt111_s5",  8'h5A, 3'd5, 3'b111, 8'h5A, 1'b0, 1, 1'b1);
    send("ror_81_7",  8'h81, 3'd7, 3'b110, 8'h03, 1'b0, 8, 1'b1);
    send("asr_7f_7",  8'h7F, 3'd7, 3'b100, 8'h00, 1'b0, 8, 1'b1);
    drain();

    // Back-pressure: result must stay put with in_ready low while out_ready is low.
    out_ready = 1'b0;
    send("pt011_hold", 8'hA6, 3'd0, 3'b011, 8'hA6, 1'b0, 1, 1'b1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    chk("hold_out_valid_seen", {31'd0, out_valid}, 32'd1);
    tick();
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    chk("hold_in_ready_after", {31'd0, in_ready}, 32'd1);
    drain();

    // Reset in the middle of a long shift must discard the operation.
    send("abort_lsr", 8'hA6, 3'd7, 3'b101, 8'h00, 1'b0, 8, 1'b0);
    tick();
    tick();
    chk("abort_busy_mid", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy",      {31'd0, busy},      32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd0);
    rst_n = 1'b1;
    tick();
    chk("abort_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("abort_no_result",      {31'd0, out_valid}, 32'd0);
    send("lsr_a6_7", 8'hA6, 3'd7, 3'b101, 8'h01, 1'b0, 8, 1'b1);
    drain();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
